// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge
//   Single-clock AHB-Lite slave to APB master bridge. Each accepted AHB-Lite
//   transfer becomes one APB SETUP/ACCESS sequence. PREADY stretches the AHB
//   data phase. An optional PREADY timeout aborts a hung APB access and
//   returns a two-cycle AHB ERROR response.
//
// Parameters
//   TIMEOUT  ACCESS cycles with PREADY low before abort (0 disables the timeout)
//   TW       timeout counter width (TIMEOUT < 2**TW)
//
// Ports
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,     AHB-Lite address phase (HSIZE is ignored,
//   HWRITE, HSIZE, HREADY    all transfers are 32-bit)
//   HWDATA                   AHB write data (data phase)
//   HREADYOUT, HRESP, HRDATA AHB slave response, all registered
//   PADDR, PWRITE, PWDATA,   APB master request, all registered
//   PSEL, PENABLE
//   PREADY, PRDATA           APB completer response
module ahb_apb_bridge #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic        PREADY,
    input  logic [31:0] PRDATA
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    localparam logic [TW-1:0] COUNT_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] count;
    logic          accept;
    logic          timeout_hit;

    logic          hreadyout_d;
    logic          hresp_d;
    logic          psel_d;
    logic          penable_d;

    // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY; size is fixed.
    logic          unused_inputs;
    assign unused_inputs = ^{HSIZE, HTRANS[0]};

    assign accept      = HSEL & HTRANS[1] & HREADY;
    assign timeout_hit = (TIMEOUT != 0) && (count == COUNT_LAST);

    // State register; the AHB/APB control outputs are registered from the
    // decode of next_state so they change exactly with the state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
        end else begin
            state     <= next_state;
            HREADYOUT <= hreadyout_d;
            HRESP     <= hresp_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
        end
    end

    // Next-state logic. PREADY is checked before the timeout so a completer
    // answering on the final allowed cycle still completes normally.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = LATCH;
            LATCH:   next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS: begin
                if (PREADY)           next_state = IDLE;
                else if (timeout_hit) next_state = ERR1;
                else                  next_state = ACCESS;
            end
            ERR1:    next_state = ERR2;
            ERR2:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode of the upcoming state.
    always_comb begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        case (next_state)
            IDLE:    hreadyout_d = 1'b1;
            SETUP:   psel_d      = 1'b1;
            ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ERR1:    hresp_d     = 1'b1;
            ERR2: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // APB request, read data and timeout counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            HRDATA <= '0;
            count  <= '0;
        end else begin
            if (state == IDLE && accept) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
            end
            // HWDATA is valid in the AHB data phase, which is the LATCH cycle.
            if (state == LATCH && PWRITE) begin
                PWDATA <= HWDATA;
            end
            if (state == ACCESS && PREADY && !PWRITE) begin
                HRDATA <= PRDATA;
            end
            if (state == SETUP) begin
                count <= '0;
            end else if (state == ACCESS && !PREADY && !timeout_hit) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge
//   Self-checking bench for ahb_apb_bridge (built with TIMEOUT=4). Inputs are
//   driven and outputs sampled on the falling edge of PCLK. A behavioural APB
//   completer inside run_xfer answers after a chosen number of wait cycles;
//   expected transfer timing comes from a small arithmetic model of the
//   bridge's rules (3 wait states + one per APB wait, or abort after TIMEOUT).
module tb_ahb_apb_bridge;

    localparam int TO = 4;

    logic        PCLK;
    logic        PRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PREADY;
    logic [31:0] PRDATA;

    ahb_apb_bridge #(.TIMEOUT(TO), .TW(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference state: what the bridge must be holding between transfers.
    logic [31:0] m_paddr  = '0;
    logic [31:0] m_pwdata = '0;
    logic [31:0] m_hrdata = '0;

    // Observations of the last transfer.
    int          r_done, r_psel_first, r_pen_first, r_pen_cnt, r_psel_cnt;
    int          r_hresp_cnt, r_unstable;
    logic        r_hresp_done;
    logic [31:0] r_paddr_c0, r_paddr_c1, r_hrdata;

    // Called at a falling edge with the bridge ready; drives the address phase
    // there (cycle 0) and returns at the falling edge of the completion cycle.
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input logic [31:0] exp_pw);
        int acc;
        acc          = 0;
        r_done       = 0;
        r_psel_first = 0;
        r_pen_first  = 0;
        r_pen_cnt    = 0;
        r_psel_cnt   = 0;
        r_hresp_cnt  = 0;
        r_unstable   = 0;
        r_hresp_done = 1'bx;
        r_hrdata     = 'x;
        r_paddr_c1   = 'x;
        r_paddr_c0   = PADDR;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HREADY = 1'b1;
        HWDATA = ~wdata;
        PRDATA = rdata;
        PREADY = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                r_paddr_c1 = PADDR;
                HSEL   = 1'($urandom_range(0, 1));
                HTRANS = 2'b00;
                HADDR  = $urandom;
                HWRITE = 1'($urandom_range(0, 1));
                HREADY = 1'($urandom_range(0, 1));
                HWDATA = wdata;
            end else begin
                HWDATA = $urandom;
            end
            if (PSEL) begin
                r_psel_cnt++;
                if (r_psel_first == 0) r_psel_first = c;
                if (PADDR !== addr || PWRITE !== wr || PWDATA !== exp_pw) r_unstable++;
            end
            if (PENABLE) begin
                r_pen_cnt++;
                if (r_pen_first == 0) r_pen_first = c;
            end
            if (HRESP) r_hresp_cnt++;
            if (HREADYOUT) begin
                r_done       = c;
                r_hresp_done = HRESP;
                r_hrdata     = HRDATA;
                HREADY       = 1'b1;
                PREADY       = 1'b1;
                break;
            end
            if (PSEL && PENABLE) begin
                PREADY = (acc >= waits);
                acc++;
            end else begin
                PREADY = 1'b1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int g = 0; g < n; g++) begin
            HSEL   = 1'($urandom_range(0, 1));
            HTRANS = 2'b00;
            HREADY = 1'b1;
            @(negedge PCLK);
        end
    endtask

    // Runs one transfer and compares it against the timing/data rules.
    task automatic xfer_check(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        logic ok;
        int   exp_pen;
        logic [31:0] exp_pw;
        ok      = (waits < TO);
        exp_pen = ok ? waits + 1 : TO;
        exp_pw  = wr ? wdata : m_pwdata;
        run_xfer(wr, addr, wdata, rdata, waits, exp_pw);
        chk({tag, " done_cycle"},  r_done,       ok ? 4 + waits : 4 + TO);
        chk({tag, " psel_first"},  r_psel_first, 2);
        chk({tag, " pen_first"},   r_pen_first,  3);
        chk({tag, " pen_cycles"},  r_pen_cnt,    exp_pen);
        chk({tag, " psel_cycles"}, r_psel_cnt,   exp_pen + 1);
        chk({tag, " hresp_cycles"}, r_hresp_cnt, ok ? 0 : 2);
        chk({tag, " hresp_done"},  {31'd0, r_hresp_done}, {31'd0, !ok});
        chk({tag, " paddr_before"}, r_paddr_c0,  m_paddr);
        chk({tag, " paddr_latch"}, r_paddr_c1,   addr);
        chk({tag, " apb_unstable"}, r_unstable,  0);
        m_paddr = addr;
        if (wr) m_pwdata = wdata;
        if (!wr && ok) m_hrdata = rdata;
        chk({tag, " hrdata"}, r_hrdata, m_hrdata);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          gap;
        logic [31:0] exp_hrdata;
        int          exp_done;
    } vec_t;

    typedef struct {
        logic       sel;
        logic [1:0] trans;
        logic       rdy;
    } noacc_t;

    vec_t   tbl[7];
    noacc_t na[5];

    initial begin
        int   act;
        logic prev_err;

        tbl[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0,         0,  1, 32'h0,         4};
        tbl[1] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 2,  1, 32'h1234_5678, 6};
        tbl[2] = '{1'b0, 32'h00AB_0040, 32'h0,         32'hDEAD_BEEF, 0,  1, 32'hDEAD_BEEF, 4};
        tbl[3] = '{1'b1, 32'h0000_0030, 32'hCAFE_0003, 32'h0,         1,  1, 32'hDEAD_BEEF, 5};
        tbl[4] = '{1'b0, 32'h0000_0034, 32'h0,         32'h0BAD_F00D, 0,  0, 32'h0BAD_F00D, 4};
        tbl[5] = '{1'b0, 32'h0000_0040, 32'h0,         32'h1111_1111, 50, 1, 32'h0BAD_F00D, 8};
        tbl[6] = '{1'b1, 32'h0000_0044, 32'h7777_0006, 32'h0,         0,  1, 32'h0BAD_F00D, 4};

        na[0] = '{1'b0, 2'b10, 1'b1};
        na[1] = '{1'b1, 2'b00, 1'b1};
        na[2] = '{1'b1, 2'b01, 1'b1};
        na[3] = '{1'b1, 2'b10, 1'b0};
        na[4] = '{1'b1, 2'b11, 1'b0};

        PRESETn = 1'b0;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
        HREADY = 1'b1; HWDATA = '0; PREADY = 1'b1; PRDATA = '0;
        repeat (2) @(negedge PCLK);

        chk("rst HREADYOUT", {31'd0, HREADYOUT}, 32'd1);
        chk("rst HRESP",     {31'd0, HRESP},     32'd0);
        chk("rst HRDATA",    HRDATA,             32'd0);
        chk("rst PADDR",     PADDR,              32'd0);
        chk("rst PWRITE",    {31'd0, PWRITE},    32'd0);
        chk("rst PWDATA",    PWDATA,             32'd0);
        chk("rst PSEL",      {31'd0, PSEL},      32'd0);
        chk("rst PENABLE",   {31'd0, PENABLE},   32'd0);

        PRESETn = 1'b1;
        @(negedge PCLK);

        // Address phases that must not be accepted.
        foreach (na[i]) begin
            act = 0;
            HSEL = na[i].sel; HTRANS = na[i].trans; HREADY = na[i].rdy;
            HADDR = $urandom; HWRITE = 1'($urandom_range(0, 1));
            for (int k = 0; k < 3; k++) begin
                @(negedge PCLK);
                if (PSEL || PENABLE || !HREADYOUT || HRESP) act++;
            end
            chk($sformatf("noaccept[%0d] activity", i), act, 0);
            chk($sformatf("noaccept[%0d] paddr", i), PADDR, m_paddr);
        end
        idle_cycles(1);

        // Directed vectors, including back-to-back (gap 0) and timeout.
        foreach (tbl[i]) begin
            idle_cycles(tbl[i].gap);
            xfer_check($sformatf("tbl[%0d]", i), tbl[i].wr, tbl[i].addr,
                       tbl[i].wdata, tbl[i].rdata, tbl[i].waits);
            chk($sformatf("tbl[%0d] const_done", i),   r_done,   tbl[i].exp_done);
            chk($sformatf("tbl[%0d] const_hrdata", i), r_hrdata, tbl[i].exp_hrdata);
        end

        // Random transfers; an ERROR completion is never followed directly by
        // a new address phase because ERR2 does not sample one.
        prev_err = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic        wr;
            logic [31:0] addr, wdata, rdata;
            int          waits;
            wr    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            waits = $urandom_range(0, 5);
            idle_cycles(prev_err ? $urandom_range(1, 2) : $urandom_range(0, 2));
            xfer_check($sformatf("rnd[%0d]", n), wr, addr, wdata, rdata, waits);
            prev_err = (waits >= TO);
        end

        // Reset while in ACCESS.
        idle_cycles(2);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0050; HWRITE = 1'b0; HREADY = 1'b1;
        PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
        repeat (3) @(negedge PCLK);
        HTRANS = 2'b00;
        chk("midrst PSEL before",    {31'd0, PSEL},    32'd1);
        chk("midrst PENABLE before", {31'd0, PENABLE}, 32'd1);
        #1 PRESETn = 1'b0;
        #1;
        chk("midrst PSEL",      {31'd0, PSEL},      32'd0);
        chk("midrst PENABLE",   {31'd0, PENABLE},   32'd0);
        chk("midrst HREADYOUT", {31'd0, HREADYOUT}, 32'd1);
        chk("midrst HRESP",     {31'd0, HRESP},     32'd0);
        chk("midrst PADDR",     PADDR,              32'd0);
        chk("midrst HRDATA",    HRDATA,             32'd0);
        HSEL = 1'b1; HTRANS = 2'b00; HREADY = 1'b1; PREADY = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b1;
        act = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge PCLK);
            if (PSEL || PENABLE || !HREADYOUT || HRESP) act++;
        end
        chk("postrst idle activity", act, 0);
        chk("postrst PADDR", PADDR, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

Single-clock AHB-Lite slave to APB master bridge that sits directly upstream of the APB fabric and slave decoder. It converts each AHB-Lite transfer into one APB SETUP/ACCESS sequence on PADDR/PWRITE/PWDATA/PSEL/PENABLE. It waits on PREADY and returns PRDATA to the AHB side. An optional PREADY timeout converts a hung APB access into an AHB two-cycle ERROR response.

## Interface

Parameters:
- TIMEOUT, default 255: maximum number of ACCESS cycles with PREADY low before the transfer is aborted. A value of 0 disables the timeout.
- TW, default 8: width of the timeout counter. TIMEOUT must be less than 2^TW.

Ports:
- PCLK  in  1  single clock for both the AHB and APB sides.
- PRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  AHB slave select.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type. Only NONSEQ (2'b10) and SEQ (2'b11) start a transfer.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  ignored; all transfers are 32-bit.
- HREADY  in  1  bus-level HREADY, used to qualify the address phase.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  this slave's ready output.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  registered read data.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PSEL  out  1  high during SETUP and ACCESS. It may be left unconnected when the fabric decodes from PADDR.
- PENABLE  out  1  high during ACCESS only.
- PREADY  in  1  APB ready from the fabric. Unmapped addresses return ready=1.
- PRDATA  in  32  APB read data. Unmapped addresses return 32'hDEADBEEF.

## Operation

- The transfer is accepted in IDLE when HSEL & HTRANS[1] & HREADY. On acceptance, HADDR→PADDR and HWRITE→PWRITE are registered.
- FSM states and transitions (all outputs registered):
  - IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0. On an accepted transfer → LATCH; otherwise stay in IDLE.
  - LATCH: HREADYOUT=0. HWDATA→PWDATA is registered for writes only. → SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Timeout counter is cleared. → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0.
    - If PREADY=1: PRDATA→HRDATA is registered on reads, then → IDLE.
    - Else, if TIMEOUT≠0 and count==TIMEOUT-1: → ERR1.
    - Else: count+1 and stay in ACCESS.
  - ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1. → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. → IDLE.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS. After completion they keep their last values until the next accepted transfer.
- HRDATA changes only on a completed read. Writes and timed-out reads leave it unchanged.
- HTRANS IDLE/BUSY, HSEL=0 or HREADY=0 in IDLE: no APB activity and no state change.
- Only IDLE samples the AHB address phase. The bridge holds HREADYOUT=0 during busy states, so the bus cannot present a new address phase then.
- Timeout counter: TW bits, saturating is not required because the abort happens at TIMEOUT-1.

## Timing

- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PWRITE=0, PWDATA=0, PSEL=0, PENABLE=0, state IDLE, counter 0.
- Asserting PRESETn at any time, including mid-ACCESS, forces all outputs to their reset values immediately. Deassertion is synchronous to PCLK by system convention.
- Cycle timeline with the address phase in cycle 0 and a zero-wait APB slave:
  - cycle 1: LATCH.
  - cycle 2: SETUP.
  - cycle 3: ACCESS, PREADY=1.
  - cycle 4: IDLE, HREADYOUT=1, HRDATA valid.
  - This gives 3 AHB wait states.
- Each APB wait cycle adds exactly one AHB wait state.
- Back-to-back: a new address phase presented in the completion cycle (cycle 4) is accepted in that cycle. Its SETUP is in cycle 6.
- Timeout: with PREADY stuck low, ACCESS lasts exactly TIMEOUT cycles. ERR1 follows, then ERR2; HRESP=1 in both cycles, and HREADYOUT is low then high.
- Response to PREADY=1 arriving in the same cycle as count==TIMEOUT-1: PREADY wins and the transfer completes normally.

## Test plan

- Write with a zero-wait slave: HADDR=0x0000_0010, HWDATA=0xA5A5_0001.
  - Required: PSEL rises in cycle 2, PENABLE in cycle 3, PWDATA=0xA5A5_0001 throughout.
  - Required: HREADYOUT low for cycles 1-3, HRESP=0.
- Read with 2 APB wait states and PRDATA=0x1234_5678.
  - Required: ACCESS lasts 3 cycles; HREADYOUT returns to 1 in cycle 6 with HRDATA=0x1234_5678.
- Read from an unmapped address (PADDR[23:16]≠0, fabric returns DEADBEEF with PREADY=1).
  - Required: HRDATA=0xDEADBEEF, cycle timing as in the zero-wait case.
- Back-to-back write then read, with the second NONSEQ issued in the completion cycle.
  - Required: the second transfer is accepted with no idle gap; PADDR updates at the second LATCH; no spurious PENABLE.
- TIMEOUT=4 with PREADY held low.
  - Required: PENABLE high for exactly 4 cycles, then ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
  - Required: HRDATA unchanged; the next transfer proceeds normally.
- PRESETn asserted during ACCESS, then HTRANS=IDLE with HSEL=1.
  - Required: PSEL, PENABLE and HREADYOUT take their reset values immediately.
  - Required: after release, the IDLE transfer produces no APB activity.
